// File: rtl/operand_sequencer.sv
// operand_sequencer: feeds four latched operands (A, B, C, X) one at a time
// to an external evaluator using a press/release strobe on go, then waits for
// the evaluator's result and holds it on result with a one-cycle done pulse.
// Optional feature: define OPSEQ_TIMEOUT_EN to abandon WAIT_RESULT after
// TIMEOUT_CYCLES cycles. The capture is then forced and the sticky timeout flag is set.
// Without the macro the block waits indefinitely and timeout is tied low.
module operand_sequencer #(
    parameter int GO_HIGH_CYCLES = 2,
    parameter int GO_LOW_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       start,
    input  logic [7:0] coef_a,
    input  logic [7:0] coef_b,
    input  logic [7:0] coef_c,
    input  logic [7:0] coef_x,
    output logic       go,
    output logic [7:0] data_out,
    input  logic [7:0] result_in,
    input  logic       result_valid_in,
    output logic       busy,
    output logic [7:0] result,
    output logic       done,
    output logic       timeout
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SETUP       = 3'd1,
        PRESS       = 3'd2,
        RELEASE     = 3'd3,
        WAIT_RESULT = 3'd4,
        DONE        = 3'd5
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [3:0]  phase_cnt_reg;
    logic [1:0]  idx_reg;
    logic [7:0]  shadow_reg [4];
    logic [7:0]  coef_vec [4];
    logic [7:0]  result_reg;
    logic        accept;
    logic        press_last;
    logic        release_last;
    logic        timeout_hit;

    assign accept       = (state_reg == IDLE) && start;
    assign press_last   = (phase_cnt_reg == 4'(GO_HIGH_CYCLES - 1));
    assign release_last = (phase_cnt_reg == 4'(GO_LOW_CYCLES - 1));

    assign coef_vec[0] = coef_a;
    assign coef_vec[1] = coef_b;
    assign coef_vec[2] = coef_c;
    assign coef_vec[3] = coef_x;

`ifdef OPSEQ_TIMEOUT_EN
    logic [7:0] wait_cnt_reg;
    logic       timeout_reg;

    assign timeout_hit = (state_reg == WAIT_RESULT) &&
                         (wait_cnt_reg == 8'(TIMEOUT_CYCLES - 1));

    // Wait counter: counts WAIT_RESULT cycles, cleared on any state entry
    always_ff @(posedge clk) begin
        if (Reset || (state_next != state_reg) || (state_reg != WAIT_RESULT))
            wait_cnt_reg <= 8'd0;
        else
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
    end

    // Sticky timeout flag: set by a forced capture, cleared by a new run
    always_ff @(posedge clk) begin
        if (Reset)
            timeout_reg <= 1'b0;
        else if (accept)
            timeout_reg <= 1'b0;
        else if (timeout_hit && !result_valid_in)
            timeout_reg <= 1'b1;
    end

    assign timeout = timeout_reg;
`else
    assign timeout_hit = 1'b0;
    assign timeout     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (Reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:        if (start) state_next = SETUP;
            SETUP:       state_next = PRESS;
            PRESS:       if (press_last) state_next = RELEASE;
            RELEASE:     if (release_last)
                             state_next = (idx_reg == 2'd3) ? WAIT_RESULT : SETUP;
            WAIT_RESULT: if (result_valid_in || timeout_hit) state_next = DONE;
            DONE:        state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        busy     = (state_reg != IDLE);
        go       = (state_reg == PRESS);
        done     = (state_reg == DONE);
        data_out = 8'd0;
        if ((state_reg == SETUP) || (state_reg == PRESS) || (state_reg == RELEASE))
            data_out = shadow_reg[idx_reg];
    end

    // Phase counter: counts cycles spent in the current state
    always_ff @(posedge clk) begin
        if (Reset || (state_next != state_reg) || (state_reg == IDLE))
            phase_cnt_reg <= 4'd0;
        else
            phase_cnt_reg <= phase_cnt_reg + 4'd1;
    end

    // Operand index: restarts on accept, advances at the end of each release
    always_ff @(posedge clk) begin
        if (Reset)
            idx_reg <= 2'd0;
        else if (accept)
            idx_reg <= 2'd0;
        else if ((state_reg == RELEASE) && release_last && (idx_reg != 2'd3))
            idx_reg <= idx_reg + 2'd1;
    end

    // Shadow operand registers: loaded only on an accepted start
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_shadow
            always_ff @(posedge clk) begin
                if (Reset)
                    shadow_reg[gi] <= 8'd0;
                else if (accept)
                    shadow_reg[gi] <= coef_vec[gi];
            end
        end
    endgenerate

    // Result capture: a valid result wins over a simultaneous timeout
    always_ff @(posedge clk) begin
        if (Reset)
            result_reg <= 8'd0;
        else if ((state_reg == WAIT_RESULT) && (result_valid_in || timeout_hit))
            result_reg <= result_in;
    end

    assign result = result_reg;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer at default parameters. A small
// evaluator model latches data_out on each go rising edge and computes
// A*X*X + B*X + C (mod 256), which is compared with hand-computed values.
// The timeout scenario follows OPSEQ_TIMEOUT_EN in the same way as the design.
module tb_operand_sequencer;

    logic       clk = 1'b0;
    logic       Reset;
    logic       start;
    logic [7:0] coef_a, coef_b, coef_c, coef_x;
    logic       go;
    logic [7:0] data_out;
    logic [7:0] result_in;
    logic       result_valid_in;
    logic       busy;
    logic [7:0] result;
    logic       done;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    logic [7:0] cap [4];
    int         cap_n;
    logic [7:0] eval_res;

    operand_sequencer dut (
        .clk             (clk),
        .Reset           (Reset),
        .start           (start),
        .coef_a          (coef_a),
        .coef_b          (coef_b),
        .coef_c          (coef_c),
        .coef_x          (coef_x),
        .go              (go),
        .data_out        (data_out),
        .result_in       (result_in),
        .result_valid_in (result_valid_in),
        .busy            (busy),
        .result          (result),
        .done            (done),
        .timeout         (timeout)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept a start and walk the 20 operand-phase cycles, checking go and
    // data_out each cycle. Ends on the first WAIT_RESULT cycle.
    // With noise set, start is re-pulsed with different operands while busy.
    task automatic send_ops(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] x,
                            input bit noise);
        logic [7:0] ops [4];
        logic       prev_go;
        ops[0] = a; ops[1] = b; ops[2] = c; ops[3] = x;
        chk("idle_busy", busy, 0);
        coef_a = a; coef_b = b; coef_c = c; coef_x = x;
        start = 1'b1;
        step();
        start = 1'b0;
        cap_n = 0;
        prev_go = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_timeout_clr", timeout, 0);
        for (int p = 1; p <= 20; p++) begin
            int k;
            int ph;
            k  = (p - 1) / 5;
            ph = (p - 1) % 5;
            if (noise && p == 3) begin
                start = 1'b1;
                coef_a = 8'hFF; coef_b = 8'hFF; coef_c = 8'hFF; coef_x = 8'hFF;
            end
            if (noise && p == 4) start = 1'b0;
            $display("cycle p=%0d go=%0b data_out=%0d", p, go, data_out);
            chk($sformatf("go_p%0d", p), go, (ph == 1 || ph == 2) ? 1 : 0);
            chk($sformatf("data_p%0d", p), data_out, ops[k]);
            if (go && !prev_go && cap_n < 4) begin
                cap[cap_n] = data_out;
                cap_n++;
            end
            prev_go = go;
            step();
        end
        chk("go_pulses", cap_n, 4);
        chk("wait_go", go, 0);
        chk("wait_data", data_out, 0);
        chk("wait_busy", busy, 1);
        eval_res = 8'(cap[0] * cap[3] * cap[3] + cap[1] * cap[3] + cap[2]);
    endtask

    // Return the evaluator result after 'delay' WAIT_RESULT cycles
    task automatic finish_ok(input int delay, input logic [7:0] exp);
        for (int i = 0; i < delay; i++) begin
            chk("wait_no_done", done, 0);
            step();
        end
        result_in = eval_res;
        result_valid_in = 1'b1;
        step();
        result_valid_in = 1'b0;
        $display("transaction result=%0d expected=%0d done=%0b timeout=%0b",
                 result, exp, done, timeout);
        chk("done_pulse", done, 1);
        chk("result", result, exp);
        chk("timeout_clear", timeout, 0);
        step();
        chk("done_low", done, 0);
        chk("back_idle", busy, 0);
        chk("result_held", result, exp);
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0;
        coef_a = 8'd0; coef_b = 8'd0; coef_c = 8'd0; coef_x = 8'd0;
        result_in = 8'd0; result_valid_in = 1'b0;
        step();
        step();
        chk("rst_go", go, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", data_out, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_timeout", timeout, 0);
        Reset = 1'b0;
        step();

        // Basic run: 2*25 + 3*5 + 4 = 69
        send_ops(8'd2, 8'd3, 8'd4, 8'd5, 1'b0);
        finish_ok(3, 8'd69);

        // Overflow: 10*100 = 1000 mod 256 = 232, result on first WAIT cycle
        send_ops(8'd10, 8'd0, 8'd0, 8'd10, 1'b0);
        finish_ok(0, 8'd232);

        // Start re-pulsed while busy: 1*16 + 2*4 + 3 = 27
        send_ops(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
        finish_ok(1, 8'd27);
        chk("noise_idle", busy, 0);

        // No result from the evaluator
        send_ops(8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
        result_in = 8'h5A;
        result_valid_in = 1'b0;
`ifdef OPSEQ_TIMEOUT_EN
        for (int i = 0; i < 15; i++) step();
        chk("to_still_wait", busy, 1);
        chk("to_no_done", done, 0);
        step();
        $display("transaction timeout result=%0h done=%0b timeout=%0b", result, done, timeout);
        chk("to_done", done, 1);
        chk("to_result", result, 8'h5A);
        chk("to_flag", timeout, 1);
        step();
        chk("to_idle", busy, 0);
        chk("to_sticky", timeout, 1);
`else
        for (int i = 0; i < 40; i++) step();
        chk("nto_wait", busy, 1);
        chk("nto_done", done, 0);
        chk("nto_flag", timeout, 0);
        result_valid_in = 1'b1;
        step();
        result_valid_in = 1'b0;
        $display("transaction late result=%0h done=%0b timeout=%0b", result, done, timeout);
        chk("nto_done_pulse", done, 1);
        chk("nto_result", result, 8'h5A);
        chk("nto_flag_after", timeout, 0);
        step();
        chk("nto_idle", busy, 0);
`endif

        // Mid-run reset during PRESS of operand C
        coef_a = 8'd9; coef_b = 8'd8; coef_c = 8'd7; coef_x = 8'd6;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 11; i++) step();
        chk("mid_press_go", go, 1);
        chk("mid_press_data", data_out, 8'd7);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        $display("transaction mid-run reset go=%0b busy=%0b data_out=%0d result=%0d",
                 go, busy, data_out, result);
        chk("mid_rst_go", go, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_timeout", timeout, 0);
        step();

        // Clean run after reset: 7*9 + 1*3 + 1 = 67
        send_ops(8'd7, 8'd1, 8'd1, 8'd3, 1'b0);
        finish_ok(2, 8'd67);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
